// File: rtl/game_flow_if.sv
// game_flow_if: tap/box/pipe inputs and tick/tap/state/score outputs of the flappy-box sequencer.
// HIGH_SCORE_EN adds the high_score signal.
interface game_flow_if #(parameter int SCORE_W = 8);
    logic               tap_key;
    logic [6:0]         box_y;
    logic               pipe_hit;
    logic               pipe_passed;
    logic               tick_en;
    logic               tap_pulse;
    logic               box_reset;
    logic [1:0]         state;
    logic [SCORE_W-1:0] score;
`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score;
    modport master (output tap_key, box_y, pipe_hit, pipe_passed,
                    input  tick_en, tap_pulse, box_reset, state, score, high_score);
    modport slave  (input  tap_key, box_y, pipe_hit, pipe_passed,
                    output tick_en, tap_pulse, box_reset, state, score, high_score);
`else
    modport master (output tap_key, box_y, pipe_hit, pipe_passed,
                    input  tick_en, tap_pulse, box_reset, state, score);
    modport slave  (input  tap_key, box_y, pipe_hit, pipe_passed,
                    output tick_en, tap_pulse, box_reset, state, score);
`endif
endinterface

// File: rtl/game_flow_controller.sv
// game_flow_controller: game tick divider, tap conditioning and IDLE/PLAYING/DYING/GAME_OVER flow.
// Optional HIGH_SCORE_EN keeps the best score across runs until reset.
module game_flow_controller #(
    parameter int         TICK_DIV    = 50_000_000/60,
    parameter logic [6:0] FLOOR_Y     = 7'd120,
    parameter int         DEATH_TICKS = 30,
    parameter int         SCORE_W     = 8
) (
    input logic        i_game_clk,
    input logic        i_resetn,
    game_flow_if.slave bus
);
    localparam logic [1:0] IDLE      = 2'b00;
    localparam logic [1:0] PLAYING   = 2'b01;
    localparam logic [1:0] DYING     = 2'b10;
    localparam logic [1:0] GAME_OVER = 2'b11;
    localparam int DW = $clog2(TICK_DIV);
    localparam int CW = $clog2(DEATH_TICKS + 1);
    localparam logic [DW-1:0] DIV_MAX   = DW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DEATH_MAX = CW'(DEATH_TICKS - 1);

    logic [1:0]         r_state;
    logic [DW-1:0]      r_div;
    logic [CW-1:0]      r_death;
    logic [1:0]         r_sync;
    logic               r_sync_d;
    logic               r_tap_rise;
    logic               r_tick_en;
    logic               r_tap_pulse;
    logic [SCORE_W-1:0] r_score;
    logic               w_play;
    logic               w_run;
    logic               w_tick;
    logic               w_coll;
    logic               w_die;
    logic               w_over;

    always_comb begin
        w_play = r_state == PLAYING;
        w_run  = w_play || r_state == DYING;
        w_tick = w_run && r_div == DIV_MAX;
        w_coll = bus.box_y >= FLOOR_Y || bus.box_y == 7'd0 || bus.pipe_hit;
        w_die  = w_play && w_tick && w_coll;
        w_over = r_state == DYING && w_tick && r_death == DEATH_MAX;
    end

    // Two-flop synchroniser plus a registered edge detector: tap_rise lands 3 cycles after the key.
    always_ff @(posedge i_game_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_sync     <= '0;
            r_sync_d   <= 1'b0;
            r_tap_rise <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], bus.tap_key};
            r_sync_d   <= r_sync[1];
            r_tap_rise <= r_sync[1] & ~r_sync_d;
        end
    end

    always_ff @(posedge i_game_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_div       <= '0;
            r_tick_en   <= 1'b0;
            r_tap_pulse <= 1'b0;
        end else begin
            r_div       <= (!w_run || r_div == DIV_MAX) ? '0 : r_div + 1'b1;
            r_tick_en   <= w_play && w_tick && !w_coll;
            r_tap_pulse <= w_play && r_tap_rise && !w_die;
        end
    end

    always_ff @(posedge i_game_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= IDLE;
            r_death <= '0;
            r_score <= '0;
        end else begin
            case (r_state)
                IDLE: if (r_tap_rise) begin
                    r_state <= PLAYING;
                    r_score <= '0;
                end
                PLAYING: if (w_die) begin
                    r_state <= DYING;
                    r_death <= '0;
                end else if (bus.pipe_passed && !(&r_score)) begin
                    r_score <= r_score + 1'b1;
                end
                DYING: if (w_over) begin
                    r_state <= GAME_OVER;
                    r_death <= '0;
                end else if (w_tick) begin
                    r_death <= r_death + 1'b1;
                end
                default: if (r_tap_rise) r_state <= IDLE;
            endcase
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] r_high;
    always_ff @(posedge i_game_clk or negedge i_resetn) begin
        if (!i_resetn) r_high <= '0;
        else if (w_over && r_score > r_high) r_high <= r_score;
    end
    assign bus.high_score = r_high;
`endif

    assign bus.tick_en   = r_tick_en;
    assign bus.tap_pulse = r_tap_pulse;
    assign bus.box_reset = r_state == IDLE;
    assign bus.state     = r_state;
    assign bus.score     = r_score;
endmodule
